mole_button_encoder: RTL and testbench

Input-side front end for the whack-a-mole game: conditions the nine breadboard push buttons and turns each clean press into a single indexed hit event. It synchronises and debounces each button, then queues press events in a small FIFO. Events go to the game core over a valid/ready handshake. The game core drives the mole LEDs and consumes these events instead of sampling raw SW levels with its own debounce counter.

---
 rtl/mole_pkg.sv | 7 +
 rtl/mole_button_encoder_if.sv | 9 +
 rtl/btn_debounce.sv | 27 ++
 rtl/mole_button_encoder.sv | 66 ++++++
 tb/tb_mole_button_encoder.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/mole_pkg.sv
// mole_pkg: constants and types shared by the button front end and the game core
package mole_pkg;
  localparam int N_BTN_DEF = 9;
  localparam int IDX_W = 4;
  localparam int DEB_CYCLES_DEF = 100000;
  typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/mole_button_encoder_if.sv
// mole_button_encoder_if: valid/ready hit-event channel from the button encoder to the game core
interface mole_button_encoder_if;
  import mole_pkg::*;
  logic hit_valid;
  idx_t hit_idx;
  logic hit_ready;
  modport master (output hit_valid, hit_idx, input hit_ready);
  modport slave (input hit_valid, hit_idx, output hit_ready);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser plus stable-count debouncer for one button
module btn_debounce #(
  parameter int DEB_CYCLES = 100000
) (
  input  logic cin,
  input  logic rst,
  input  logic sw,
  output logic stable
);
  localparam int CW = $clog2(DEB_CYCLES);
  logic [1:0] sync_r;
  logic [CW-1:0] cnt;
  always_ff @(posedge cin) begin
    if (rst) begin
      sync_r <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], sw};
      if (sync_r[1] == stable) cnt <= '0;
      else if (cnt == CW'(DEB_CYCLES - 1)) begin
        stable <= ~stable;
        cnt    <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mole_button_encoder.sv
// mole_button_encoder: debounced buttons -> pending latches -> priority arbiter -> hit-event FIFO
module mole_button_encoder
  import mole_pkg::*;
#(
  parameter int N_BTN      = N_BTN_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  cin,
  input  logic                  rst,
  input  logic [N_BTN-1:0]      SW,
  output logic [N_BTN-1:0]      btn_level,
  mole_button_encoder_if.master hit,
  output logic                  overflow
);
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  logic [N_BTN-1:0] stable, stable_q, press, pend, clr;
  idx_t sel;
  logic full, push, pop;
  idx_t mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [OW-1:0] occ;
  genvar g;
  generate
    for (g = 0; g < N_BTN; g++) begin : g_deb
      btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .cin    (cin),
        .rst    (rst),
        .sw     (SW[g]),
        .stable (stable[g])
      );
    end
  endgenerate
  always_comb begin
    sel = '0;
    for (int i = N_BTN - 1; i >= 0; i--) if (pend[i]) sel = idx_t'(i);
  end
  assign btn_level     = stable;
  assign press         = stable & ~stable_q;
  assign full          = occ == OW'(FIFO_DEPTH);
  assign pop           = hit.hit_valid & hit.hit_ready;
  assign push          = (|pend) & (~full | pop);
  assign clr           = push ? N_BTN'(1) << sel : '0;
  assign hit.hit_valid = occ != '0;
  assign hit.hit_idx   = hit.hit_valid ? mem[rp] : '0;
  // a press coinciding with its own pend bit draining is kept, so only a still-held pend loses it
  always_ff @(posedge cin) begin
    if (rst) begin
      stable_q <= '0;
      pend     <= '0;
      overflow <= 1'b0;
      wp       <= '0;
      rp       <= '0;
      occ      <= '0;
    end else begin
      stable_q <= stable;
      pend     <= (pend & ~clr) | press;
      overflow <= overflow | (|(press & pend & ~clr));
      if (push) wp <= wp == AW'(FIFO_DEPTH - 1) ? '0 : wp + 1'b1;
      if (pop) rp <= rp == AW'(FIFO_DEPTH - 1) ? '0 : rp + 1'b1;
      occ <= occ + OW'(push) - OW'(pop);
    end
  end
  always_ff @(posedge cin) if (push) mem[wp] <= sel;
endmodule

// File: tb/tb_mole_button_encoder.sv
// tb_mole_button_encoder: scoreboard bench for the debounced button hit-event encoder
module tb_mole_button_encoder;
  import mole_pkg::*;
  localparam int NB = 9;
  logic cin = 1'b0;
  logic rst = 1'b1;
  logic [NB-1:0] sw = '0;
  logic [NB-1:0] btn_level;
  logic overflow;
  int n_vec = 0;
  int n_err = 0;
  int n_hits = 0;
  int base;
  int sb[$];
  mole_button_encoder_if hit();
  mole_button_encoder #(.N_BTN(NB), .DEB_CYCLES(8), .FIFO_DEPTH(4)) dut (
    .cin       (cin),
    .rst       (rst),
    .SW        (sw),
    .btn_level (btn_level),
    .hit       (hit),
    .overflow  (overflow)
  );
  always #5 cin = ~cin;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge cin);
      #1;
    end
  endtask
  always @(negedge cin) begin
    if (!rst && hit.hit_valid && hit.hit_ready) begin
      n_hits++;
      if (sb.size() == 0) chk("spurious_hit", 32'(hit.hit_idx), 32'hff);
      else chk("hit_idx", 32'(hit.hit_idx), sb.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    hit.hit_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    tick();
    chk("rst_level", btn_level, 0);
    chk("rst_valid", hit.hit_valid, 0);
    chk("rst_idx", hit.hit_idx, 0);
    chk("rst_ovf", overflow, 0);
    // clean press on button 3
    hit.hit_ready = 1'b1;
    base = n_hits;
    sw[3] = 1'b1;
    sb.push_back(3);
    tick(9);
    chk("clean_lvl_early", btn_level[3], 0);
    tick();
    chk("clean_lvl", btn_level[3], 1);
    tick();
    chk("clean_valid_early", hit.hit_valid, 0);
    tick();
    chk("clean_valid", hit.hit_valid, 1);
    chk("clean_idx", hit.hit_idx, 3);
    tick();
    chk("clean_pulse_end", hit.hit_valid, 0);
    tick(8);
    sw[3] = 1'b0;
    tick(14);
    chk("clean_release_lvl", btn_level[3], 0);
    chk("clean_count", n_hits - base, 1);
    // bouncing button 5
    base = n_hits;
    for (int k = 0; k < 10; k++) begin
      sw[5] = (k % 2 == 0);
      tick(3);
      chk("bounce_hold", btn_level[5], 0);
    end
    sw[5] = 1'b1;
    sb.push_back(5);
    tick(9);
    chk("bounce_lvl_early", btn_level[5], 0);
    tick();
    chk("bounce_lvl", btn_level[5], 1);
    tick(6);
    chk("bounce_count", n_hits - base, 1);
    sw[5] = 1'b0;
    tick(14);
    // simultaneous presses
    base = n_hits;
    sw = 9'b1_0001_0001;
    sb.push_back(0);
    sb.push_back(4);
    sb.push_back(8);
    tick(12);
    chk("simul_idx0", hit.hit_idx, 0);
    tick();
    chk("simul_idx1", hit.hit_idx, 4);
    tick();
    chk("simul_idx2", hit.hit_idx, 8);
    tick();
    chk("simul_empty", hit.hit_valid, 0);
    chk("simul_count", n_hits - base, 3);
    sw = '0;
    tick(14);
    // backpressure with six presses
    hit.hit_ready = 1'b0;
    base = n_hits;
    sw = 9'b0_1110_1110;
    foreach (sb[i]) chk("sb_pre_bp", 0, 1);
    for (int b = 1; b < 8; b++) if (b != 4) sb.push_back(b);
    tick(20);
    chk("bp_occ", dut.occ, 4);
    chk("bp_pend", dut.pend, 9'b0_1100_0000);
    chk("bp_ovf", overflow, 0);
    chk("bp_idx", hit.hit_idx, 1);
    tick(5);
    chk("bp_idx_hold", hit.hit_idx, 1);
    chk("bp_valid_hold", hit.hit_valid, 1);
    hit.hit_ready = 1'b1;
    tick(10);
    chk("bp_count", n_hits - base, 6);
    chk("bp_sb_empty", sb.size(), 0);
    sw = '0;
    tick(14);
    // overflow on button 2 while the FIFO is full
    hit.hit_ready = 1'b0;
    base = n_hits;
    sw = 9'b0_0001_1011;
    sb.push_back(0);
    sb.push_back(1);
    sb.push_back(3);
    sb.push_back(4);
    tick(16);
    sw[2] = 1'b1;
    sb.push_back(2);
    tick(14);
    chk("ovf_pend2", dut.pend[2], 1);
    chk("ovf_before", overflow, 0);
    sw[2] = 1'b0;
    tick(12);
    sw[2] = 1'b1;
    tick(12);
    chk("ovf_set", overflow, 1);
    hit.hit_ready = 1'b1;
    tick(10);
    sw = '0;
    tick(14);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_count", n_hits - base, 5);
    chk("ovf_sb_empty", sb.size(), 0);
    // reset with queued events and a debounce in flight
    hit.hit_ready = 1'b0;
    sw = 9'b0_0000_0111;
    tick(15);
    sw[8] = 1'b1;
    tick(4);
    chk("pre_rst_valid", hit.hit_valid, 1);
    rst = 1'b1;
    sw = '0;
    tick();
    chk("mid_rst_valid", hit.hit_valid, 0);
    chk("mid_rst_level", btn_level, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_idx", hit.hit_idx, 0);
    sb.delete();
    rst = 1'b0;
    hit.hit_ready = 1'b1;
    base = n_hits;
    tick(25);
    chk("post_rst_count", n_hits - base, 0);
    chk("post_rst_valid", hit.hit_valid, 0);
    chk("final_sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
